// File: rtl/control_sequencer.sv
// control_sequencer
//   Microcoded control unit for the 8-bit bus machine. A microstep counter
//   walks T0..LAST_STEP for every instruction; the control word is decoded
//   combinationally from (state, step, opcode, flags). The flags register
//   captures the ALU carry/zero at the end of ADD/SUB T4 and feeds JC/JZ.
//
//   Optional feature macro: CONTROL_SEQUENCER_EARLY_END_EN
//     defined   : the step counter returns to 0 right after the last
//                 non-empty execute step of the current opcode.
//     undefined : every instruction takes LAST_STEP+1 cycles.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_RUN   | fetch/execute; step advances every clock
//   S_HALTED| HLT executed; halt=1, step frozen, all other controls 0
module control_sequencer #(
  parameter int STEP_WIDTH = 3,
  parameter int LAST_STEP  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            opcode,
  input  logic                  alu_carry,
  input  logic                  alu_zero,
  output logic                  halt,
  output logic                  mar_in,
  output logic                  ram_in,
  output logic                  ram_out,
  output logic                  ir_in,
  output logic                  ir_out,
  output logic                  pc_inc,
  output logic                  pc_out,
  output logic                  jump,
  output logic                  out_in,
  output logic                  a_in,
  output logic                  a_out,
  output logic                  b_in,
  output logic                  alu_out,
  output logic                  subtract,
  output logic                  flag_c,
  output logic                  flag_z,
  output logic [STEP_WIDTH-1:0] step
);

  typedef enum logic {
    S_RUN    = 1'b0,
    S_HALTED = 1'b1
  } state_t;

  localparam logic [STEP_WIDTH-1:0] T0     = STEP_WIDTH'(0);
  localparam logic [STEP_WIDTH-1:0] T1     = STEP_WIDTH'(1);
  localparam logic [STEP_WIDTH-1:0] T2     = STEP_WIDTH'(2);
  localparam logic [STEP_WIDTH-1:0] T3     = STEP_WIDTH'(3);
  localparam logic [STEP_WIDTH-1:0] T4     = STEP_WIDTH'(4);
  localparam logic [STEP_WIDTH-1:0] T_LAST = STEP_WIDTH'(LAST_STEP);

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  state_t state;
  logic   is_last;
  logic   is_alu_op;
  logic   hlt_now;

  assign is_alu_op = (opcode == OP_ADD) || (opcode == OP_SUB);
  assign hlt_now   = (opcode == OP_HLT) && (step == T2);

`ifdef CONTROL_SEQUENCER_EARLY_END_EN
  // Last microstep of the current opcode: stop after the last non-empty step.
  always_comb begin
    case (opcode)
      OP_LDA, OP_STA: is_last = (step >= T3);
      OP_ADD, OP_SUB: is_last = (step >= T4);
      default:        is_last = (step >= T2);
    endcase
    if (step >= T_LAST) begin
      is_last = 1'b1;
    end
  end
`else
  // Every instruction runs the full T0..LAST_STEP sequence.
  always_comb begin
    is_last = (step >= T_LAST);
  end
`endif

  // Sequencer state, microstep counter and flags register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_RUN;
      step   <= T0;
      flag_c <= 1'b0;
      flag_z <= 1'b0;
    end else begin
      case (state)
        S_RUN: begin
          if (hlt_now) begin
            // step is left on T3 as a visible marker of where HLT stopped
            state <= S_HALTED;
            step  <= step + STEP_WIDTH'(1);
          end else if (is_last) begin
            step <= T0;
          end else begin
            step <= step + STEP_WIDTH'(1);
          end
          if (is_alu_op && (step == T4)) begin
            flag_c <= alu_carry;
            flag_z <= alu_zero;
          end
        end
        S_HALTED: begin
          state <= S_HALTED;
        end
        default: begin
          state <= S_RUN;
          step  <= T0;
        end
      endcase
    end
  end

  // Control word decode; gated by rst so nothing strobes while in reset.
  always_comb begin
    halt     = 1'b0;
    mar_in   = 1'b0;
    ram_in   = 1'b0;
    ram_out  = 1'b0;
    ir_in    = 1'b0;
    ir_out   = 1'b0;
    pc_inc   = 1'b0;
    pc_out   = 1'b0;
    jump     = 1'b0;
    out_in   = 1'b0;
    a_in     = 1'b0;
    a_out    = 1'b0;
    b_in     = 1'b0;
    alu_out  = 1'b0;
    subtract = 1'b0;
    if (rst && (state == S_HALTED)) begin
      halt = 1'b1;
    end else if (rst && (state == S_RUN)) begin
      case (step)
        T0: begin
          pc_out = 1'b1;
          mar_in = 1'b1;
        end
        T1: begin
          ram_out = 1'b1;
          ir_in   = 1'b1;
          pc_inc  = 1'b1;
        end
        T2: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              ir_out = 1'b1;
              mar_in = 1'b1;
            end
            OP_LDI: begin
              ir_out = 1'b1;
              a_in   = 1'b1;
            end
            OP_JMP: begin
              ir_out = 1'b1;
              jump   = 1'b1;
            end
            OP_JC: begin
              ir_out = flag_c;
              jump   = flag_c;
            end
            OP_JZ: begin
              ir_out = flag_z;
              jump   = flag_z;
            end
            OP_OUT: begin
              a_out  = 1'b1;
              out_in = 1'b1;
            end
            OP_HLT: begin
              halt = 1'b1;
            end
            default: ;
          endcase
        end
        T3: begin
          case (opcode)
            OP_LDA: begin
              ram_out = 1'b1;
              a_in    = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              ram_out = 1'b1;
              b_in    = 1'b1;
            end
            OP_STA: begin
              a_out  = 1'b1;
              ram_in = 1'b1;
            end
            default: ;
          endcase
        end
        T4: begin
          if (is_alu_op) begin
            alu_out  = 1'b1;
            a_in     = 1'b1;
            subtract = (opcode == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer
//   Table of instructions applied back to back from reset, each row giving
//   the expected execute-step control words, instruction length and the
//   flags left behind. Expected per-cycle results go through a scoreboard
//   queue. Hand-written sequences cover reset in mid-instruction and HLT.
module tb_control_sequencer;

  logic       clk;
  logic       rst;
  logic [3:0] opcode;
  logic       alu_carry;
  logic       alu_zero;
  logic       halt, mar_in, ram_in, ram_out, ir_in, ir_out, pc_inc, pc_out;
  logic       jump, out_in, a_in, a_out, b_in, alu_out, subtract;
  logic       flag_c, flag_z;
  logic [2:0] step;

  control_sequencer #(.STEP_WIDTH(3), .LAST_STEP(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode),
    .alu_carry(alu_carry), .alu_zero(alu_zero),
    .halt(halt), .mar_in(mar_in), .ram_in(ram_in), .ram_out(ram_out),
    .ir_in(ir_in), .ir_out(ir_out), .pc_inc(pc_inc), .pc_out(pc_out),
    .jump(jump), .out_in(out_in), .a_in(a_in), .a_out(a_out), .b_in(b_in),
    .alu_out(alu_out), .subtract(subtract),
    .flag_c(flag_c), .flag_z(flag_z), .step(step)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [14:0] W_HALT    = 15'h4000;
  localparam logic [14:0] W_MAR_IN  = 15'h2000;
  localparam logic [14:0] W_RAM_IN  = 15'h1000;
  localparam logic [14:0] W_RAM_OUT = 15'h0800;
  localparam logic [14:0] W_IR_IN   = 15'h0400;
  localparam logic [14:0] W_IR_OUT  = 15'h0200;
  localparam logic [14:0] W_PC_INC  = 15'h0100;
  localparam logic [14:0] W_PC_OUT  = 15'h0080;
  localparam logic [14:0] W_JUMP    = 15'h0040;
  localparam logic [14:0] W_OUT_IN  = 15'h0020;
  localparam logic [14:0] W_A_IN    = 15'h0010;
  localparam logic [14:0] W_A_OUT   = 15'h0008;
  localparam logic [14:0] W_B_IN    = 15'h0004;
  localparam logic [14:0] W_ALU_OUT = 15'h0002;
  localparam logic [14:0] W_SUB     = 15'h0001;

  localparam logic [14:0] W_T0 = W_PC_OUT | W_MAR_IN;
  localparam logic [14:0] W_T1 = W_RAM_OUT | W_IR_IN | W_PC_INC;

  typedef struct {
    logic [3:0]  op;
    logic        c;
    logic        z;
    logic [14:0] w2;
    logic [14:0] w3;
    logic [14:0] w4;
    int          len;
    logic        fc;
    logic        fz;
  } row_t;

  typedef struct {
    logic [14:0] word;
    logic [2:0]  stp;
    logic        fc;
    logic        fz;
    string       tag;
  } sb_t;

  localparam int NROWS = 20;
  row_t rows [NROWS];
  sb_t  sbq [$];
  int   n_cmp = 0;
  int   n_err = 0;
  logic mfc, mfz;

  function automatic logic [14:0] get_word();
    return {halt, mar_in, ram_in, ram_out, ir_in, ir_out, pc_inc, pc_out,
            jump, out_in, a_in, a_out, b_in, alu_out, subtract};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_out();
    sb_t e;
    int  drivers;
    if (sbq.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard: queue empty, got 0 entries expected 1");
      return;
    end
    e = sbq.pop_front();
    chk({e.tag, " word"}, 32'(get_word()), 32'(e.word));
    chk({e.tag, " step"}, 32'(step), 32'(e.stp));
    chk({e.tag, " flags"}, 32'({flag_c, flag_z}), 32'({e.fc, e.fz}));
    drivers = int'(pc_out) + int'(ram_out) + int'(ir_out) + int'(a_out) + int'(alu_out);
    n_cmp++;
    if (drivers > 1) begin
      n_err++;
      $display("FAIL %s bus drivers: got %0d expected at most 1", e.tag, drivers);
    end
  endtask

  // One clock: queue the expectation, drive inputs, sample 1ns later, then
  // advance to the next falling edge.
  task automatic cycle(input logic [3:0] op, input logic c, input logic z,
                       input logic [14:0] ew, input logic [2:0] es,
                       input logic efc, input logic efz, input string tag);
    sb_t e;
    e.word = ew;
    e.stp  = es;
    e.fc   = efc;
    e.fz   = efz;
    e.tag  = tag;
    sbq.push_back(e);
    opcode    = op;
    alu_carry = c;
    alu_zero  = z;
    #1;
    check_out();
    @(negedge clk);
  endtask

  initial begin
    int          len;
    logic [14:0] ew;

    //               op     c     z     w2                       w3                     w4                            len fc    fz
    rows[0]  = '{4'h5, 1'b1, 1'b1, W_IR_OUT | W_A_IN,      15'h0,                 15'h0,                        3, 1'b0, 1'b0};
    rows[1]  = '{4'h2, 1'b1, 1'b0, W_IR_OUT | W_MAR_IN,    W_RAM_OUT | W_B_IN,    W_ALU_OUT | W_A_IN,           5, 1'b1, 1'b0};
    rows[2]  = '{4'h7, 1'b0, 1'b1, W_IR_OUT | W_JUMP,      15'h0,                 15'h0,                        3, 1'b1, 1'b0};
    rows[3]  = '{4'h8, 1'b0, 1'b0, 15'h0,                  15'h0,                 15'h0,                        3, 1'b1, 1'b0};
    rows[4]  = '{4'h3, 1'b0, 1'b1, W_IR_OUT | W_MAR_IN,    W_RAM_OUT | W_B_IN,    W_ALU_OUT | W_A_IN | W_SUB,   5, 1'b0, 1'b1};
    rows[5]  = '{4'h8, 1'b1, 1'b0, W_IR_OUT | W_JUMP,      15'h0,                 15'h0,                        3, 1'b0, 1'b1};
    rows[6]  = '{4'h7, 1'b1, 1'b1, 15'h0,                  15'h0,                 15'h0,                        3, 1'b0, 1'b1};
    rows[7]  = '{4'h1, 1'b1, 1'b0, W_IR_OUT | W_MAR_IN,    W_RAM_OUT | W_A_IN,    15'h0,                        4, 1'b0, 1'b1};
    rows[8]  = '{4'h4, 1'b0, 1'b0, W_IR_OUT | W_MAR_IN,    W_A_OUT | W_RAM_IN,    15'h0,                        4, 1'b0, 1'b1};
    rows[9]  = '{4'hE, 1'b1, 1'b1, W_A_OUT | W_OUT_IN,     15'h0,                 15'h0,                        3, 1'b0, 1'b1};
    rows[10] = '{4'h6, 1'b0, 1'b0, W_IR_OUT | W_JUMP,      15'h0,                 15'h0,                        3, 1'b0, 1'b1};
    rows[11] = '{4'h0, 1'b1, 1'b0, 15'h0,                  15'h0,                 15'h0,                        3, 1'b0, 1'b1};
    rows[12] = '{4'h9, 1'b1, 1'b0, 15'h0,                  15'h0,                 15'h0,                        3, 1'b0, 1'b1};
    rows[13] = '{4'hA, 1'b0, 1'b0, 15'h0,                  15'h0,                 15'h0,                        3, 1'b0, 1'b1};
    rows[14] = '{4'hB, 1'b1, 1'b1, 15'h0,                  15'h0,                 15'h0,                        3, 1'b0, 1'b1};
    rows[15] = '{4'hC, 1'b0, 1'b1, 15'h0,                  15'h0,                 15'h0,                        3, 1'b0, 1'b1};
    rows[16] = '{4'hD, 1'b1, 1'b0, 15'h0,                  15'h0,                 15'h0,                        3, 1'b0, 1'b1};
    rows[17] = '{4'h2, 1'b1, 1'b1, W_IR_OUT | W_MAR_IN,    W_RAM_OUT | W_B_IN,    W_ALU_OUT | W_A_IN,           5, 1'b1, 1'b1};
    rows[18] = '{4'h7, 1'b0, 1'b0, W_IR_OUT | W_JUMP,      15'h0,                 15'h0,                        3, 1'b1, 1'b1};
    rows[19] = '{4'h8, 1'b0, 1'b0, W_IR_OUT | W_JUMP,      15'h0,                 15'h0,                        3, 1'b1, 1'b1};

    rst       = 1'b0;
    opcode    = 4'h2;
    alu_carry = 1'b0;
    alu_zero  = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset word", 32'(get_word()), 32'h0);
    chk("reset step", 32'(step), 32'h0);
    chk("reset flags", 32'({flag_c, flag_z}), 32'h0);
    rst = 1'b1;

    mfc = 1'b0;
    mfz = 1'b0;
    for (int i = 0; i < NROWS; i++) begin
`ifdef CONTROL_SEQUENCER_EARLY_END_EN
      len = rows[i].len;
`else
      len = 5;
`endif
      for (int t = 0; t < len; t++) begin
        case (t)
          0:       ew = W_T0;
          1:       ew = W_T1;
          2:       ew = rows[i].w2;
          3:       ew = rows[i].w3;
          default: ew = rows[i].w4;
        endcase
        cycle(rows[i].op, rows[i].c, rows[i].z, ew, 3'(t), mfc, mfz,
              $sformatf("row%0d op%0h T%0d", i, rows[i].op, t));
      end
      mfc = rows[i].fc;
      mfz = rows[i].fz;
    end

    // Reset in the middle of an ADD (at T3) with both flags set.
    cycle(4'h2, 1'b0, 1'b0, W_T0, 3'd0, mfc, mfz, "rstseq T0");
    cycle(4'h2, 1'b0, 1'b0, W_T1, 3'd1, mfc, mfz, "rstseq T1");
    cycle(4'h2, 1'b0, 1'b0, W_IR_OUT | W_MAR_IN, 3'd2, mfc, mfz, "rstseq T2");
    chk("rstseq T3 before reset", 32'(get_word()), 32'(W_RAM_OUT | W_B_IN));
    rst = 1'b0;
    #1;
    chk("rstseq low word", 32'(get_word()), 32'h0);
    chk("rstseq low step", 32'(step), 32'h0);
    chk("rstseq low flags", 32'({flag_c, flag_z}), 32'h0);
    @(negedge clk);
    chk("rstseq held word", 32'(get_word()), 32'h0);
    rst = 1'b1;
    mfc = 1'b0;
    mfz = 1'b0;

    // HLT: halt at T2, then frozen at step 3 with only halt asserted.
    cycle(4'hF, 1'b0, 1'b0, W_T0, 3'd0, mfc, mfz, "hlt T0");
    cycle(4'hF, 1'b0, 1'b0, W_T1, 3'd1, mfc, mfz, "hlt T1");
    cycle(4'hF, 1'b0, 1'b0, W_HALT, 3'd2, mfc, mfz, "hlt T2");
    for (int k = 0; k < 20; k++) begin
      cycle(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            W_HALT, 3'd3, mfc, mfz, $sformatf("halted c%0d", k));
    end

    // Reset recovers from HALTED.
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    cycle(4'h0, 1'b0, 1'b0, W_T0, 3'd0, 1'b0, 1'b0, "post-halt T0");

    chk("scoreboard drained", 32'(sbq.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
